// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Contents: operand width, the 2-bit EX-stage op codes and the sequencer states.
// Latency/backpressure: n/a (types and constants only).
package hilo_pkg;

  localparam int HILO_WIDTH = 32;

  // Encodings match the EX-stage 2-bit Op field; bit 0 = unsigned, bit 1 = divide.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/hilo_if.sv
// EX-stage <-> HI/LO unit bundle: op issue, MTHI/MTLO writes, MFHI/MFLO reads.
// master = pipeline side (drives start/op/a/b/hi_we/lo_we/wdata/rd_req/rd_sel),
// slave = unit side (drives rdata/busy/stall/hi/lo); stall is the only backpressure.
interface hilo_if
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
);

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             rd_req;
  logic             rd_sel;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata, rd_req, rd_sel,
    input  rdata, busy, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata, rd_req, rd_sel,
    output rdata, busy, stall, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath: radix-2 shift-add multiply or restoring divide.
// Ports: div_i selects divide, acc_i is the current {upper,lower} accumulator, bmag_i is |b|,
// acc_o is the next accumulator. Purely combinational, no backpressure.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   bmag_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, LSB first.
    // Add |b| into the upper half when the current bit is set, then shift the
    // 65-bit {carry, upper, lower} right by one.
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, bmag_i} : '0);
    // Divide: the shifted partial remainder can need WIDTH+1 bits, so the
    // trial subtract takes the top WIDTH+1 bits of the accumulator directly.
    // The remainder is always < |b|, so the difference never exceeds WIDTH bits
    // and the top bit of diff is purely the borrow (negative) flag.
    trial = acc_i[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, bmag_i};

    acc_o = {sum, acc_i[WIDTH-1:1]};
    if (div_i) begin
      if (!diff[WIDTH]) begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// MIPS HI/LO unit: iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO writes, MFHI/MFLO reads.
// Latency: 33 clocks start-to-result for every op; MTHI/MTLO 1 clock; reads combinational.
// Backpressure: while busy, start/hi_we/lo_we/rd_req raise stall and are ignored until idle.
// Ports: clk, rst (async active-high), bus (hilo_if.slave) carrying all EX-stage signals.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  hilo_if.slave bus
);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_q, div_d;
  logic               qneg_q, qneg_d;  // negate product (mult) or quotient (div)
  logic               rneg_q, rneg_d;  // negate remainder (signed divide only)

  logic [2*WIDTH-1:0] acc_step;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               busy;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .bmag_i (bmag_q),
    .acc_o  (acc_step)
  );

  always_comb begin
    // op[0] set means unsigned: operands pass through as magnitudes.
    a_sgn    = ~bus.op[0] & bus.a[WIDTH-1];
    b_sgn    = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag    = a_sgn ? -bus.a : bus.a;
    b_mag    = b_sgn ? -bus.b : bus.b;

    prod_fix = qneg_q ? -acc_q : acc_q;
    quo_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // The upper (product / remainder) half starts cleared; the lower half
          // is seeded with |a|, which serves as the multiplier bits for a
          // multiply and as the dividend bits shifted in for a divide.
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          bmag_d  = b_mag;
          div_d   = bus.op[1];
          qneg_d  = a_sgn ^ b_sgn;
          rneg_d  = a_sgn & bus.op[1];
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          // MTHI/MTLO only land when no operation is being issued.
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bmag_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign bus.busy  = busy;
  assign bus.stall = busy & (bus.start | bus.rd_req | bus.hi_we | bus.lo_we);
  // Reads always come from the architectural registers; no in-flight bypass.
  assign bus.rdata = bus.rd_sel ? hi_q : lo_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
  import hilo_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   nb;
  int   ns;

  hilo_if #(.WIDTH(32)) bus ();

  hilo_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after the start edge; returns the number of sampled busy cycles.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b1) break;
      cycles++;
      step();
    end
  endtask

  task automatic do_op(input string tag, input op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int cyc;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(cyc);
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'd33);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = OP_MULT;
    bus.a      = '0;
    bus.b      = '0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = '0;
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
    step();
    step();
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_stall", {31'b0, bus.stall}, 32'h0);
    rst = 1'b0;
    step();

    // Arithmetic vectors, including divide-by-zero and signed overflow corners.
    do_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    do_op("div_neg_by0", OP_DIV, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'h00000001);
    do_op("div_pos_by0", OP_DIV, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
    do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MFHI and MTLO while a MULT is in flight (0x10000 * 0x30000 = 0x3_0000_0000).
    bus.op    = OP_MULT;
    bus.a     = 32'h00010000;
    bus.b     = 32'h00030000;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    bus.lo_we  = 1'b1;
    bus.wdata  = 32'hA5A5A5A5;
    #1;
    chk("mfhi_stall_on", {31'b0, bus.stall}, 32'h1);
    chk("mfhi_old_hi", bus.rdata, 32'h00000000);
    chk("mtlo_busy_lo", bus.lo, 32'h80000000);
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b1) break;
      if (bus.stall === 1'b1) ns++;
      step();
    end
    chk("mfhi_stall_cycles", 32'(ns), 32'd29);
    chk("mfhi_stall_off", {31'b0, bus.stall}, 32'h0);
    chk("mfhi_new_hi", bus.rdata, 32'h00000003);
    chk("mtlo_held_lo", bus.lo, 32'h00000000);
    step();
    bus.lo_we  = 1'b0;
    bus.rd_req = 1'b0;
    chk("mtlo_after_lo", bus.lo, 32'hA5A5A5A5);
    chk("mtlo_after_hi", bus.hi, 32'h00000003);

    // Reset in the middle of a DIV.
    bus.op    = OP_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("mid_rst_hi", bus.hi, 32'h0);
    chk("mid_rst_lo", bus.lo, 32'h0);
    step();
    rst = 1'b0;
    step();
    do_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, 32'h00000000, 32'd42);

    // start and MTHI together: operation wins, HI write dropped.
    bus.op    = OP_MULTU;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    step();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    chk("start_we_busy", {31'b0, bus.busy}, 32'h1);
    chk("start_we_hi_dropped", bus.hi, 32'h00000000);
    wait_done(nb);
    chk("start_we_cycles", 32'(nb), 32'd33);
    chk("start_we_lo", bus.lo, 32'd6);
    chk("start_we_hi", bus.hi, 32'd0);

    // Back-to-back: new start in the first idle cycle after the result lands.
    bus.op    = OP_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    #1;
    chk("b2b_no_stall", {31'b0, bus.stall}, 32'h0);
    step();
    bus.start = 1'b0;
    chk("b2b_busy", {31'b0, bus.busy}, 32'h1);
    wait_done(nb);
    chk("b2b_cycles", 32'(nb), 32'd33);
    chk("b2b_lo", bus.lo, 32'd14);
    chk("b2b_hi", bus.hi, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequential HI/LO unit for the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage and computes each one iteratively over 33 cycles. It owns the architectural HI and LO registers, services MFHI/MFLO/MTHI/MTLO, and raises a pipeline stall when an access collides with an operation in flight.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width; the only supported value is 32.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  issue a mult/div operation this cycle.
- op  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  32  rs operand (multiplicand / dividend).
- b  in  32  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO data.
- rd_req  in  1  MFHI/MFLO in EX this cycle.
- rd_sel  in  1  read select: 1 selects HI, 0 selects LO.
- rdata  out  32  combinational read of the HI or LO register.
- busy  out  1  an operation is in flight.
- stall  out  1  the pipeline must hold EX this cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation

FSM states:
- IDLE: if start, latch |a|, |b|, the result-sign flags, and the op; clear the 64-bit accumulator and the 5-bit counter; go to RUN.
- RUN: perform one iteration per cycle; counter runs 0..31; when counter is 31, go to FIX.
- FIX: apply signs, write HI and LO, go to IDLE.

Magnitudes:
- For signed ops, negative operands are two's-complement negated.
- For unsigned ops, operands pass through unchanged.

Multiply:
- Algorithm is radix-2 shift-add into a 64-bit product.
- In FIX, negate the 64-bit product if sign(a) XOR sign(b), for MULT only.
- Then HI = product[63:32], LO = product[31:0].

Divide:
- Algorithm is restoring: shift the remainder/quotient pair left by 1, trial-subtract |b|, and set the quotient bit when the result is non-negative.
- In FIX, negate the quotient if sign(a) XOR sign(b), and negate the remainder if sign(a), for DIV only.
- LO = quotient, HI = remainder.

Divide by zero (no exception):
- The raw algorithm yields quotient 0xFFFFFFFF and remainder |a|.
- After sign fix, DIVU gives LO=0xFFFFFFFF, HI=a.
- After sign fix, DIV gives LO = 1 if a<0, else 0xFFFFFFFF, and HI=a.

Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.

MTHI/MTLO:
- In IDLE, hi_we/lo_we write wdata into HI/LO at the next edge.
- Both may be asserted in the same cycle.

Priority in IDLE: start beats hi_we/lo_we in the same cycle; the write is dropped.

While busy:
- start, hi_we, and lo_we are ignored and stalled.
- The upstream stage holds them asserted until accepted.

Read and stall:
- rdata = rd_sel ? HI : LO, always taken from the registers.
- Bypass of an in-flight result is not provided.
- stall = busy AND (start OR rd_req OR hi_we OR lo_we).

## Timing

- Reset values: state=IDLE; HI=0, LO=0, rdata=0, busy=0, stall=0; counter and accumulator cleared.
- Reset mid-operation aborts the operation and leaves HI=LO=0.
- start is sampled at edge E0.
- RUN spans edges E1..E32.
- FIX writes HI and LO at edge E33.
- busy is high for the 33 cycles after E0. It is low again, with the new HI/LO visible, in the cycle after E33.
- Latency from start to result is 33 clocks, for every op and every operand value; there is no early termination.
- A start presented in the cycle after E33 is accepted, giving back-to-back operations with no bubble.
- MTHI/MTLO latency is 1 clock.

## Structure

Shared package `hilo_pkg` holds:
- the op encodings MULT/MULTU/DIV/DIVU (matching the existing 2-bit Op code);
- the FSM state enum IDLE/RUN/FIX;
- the WIDTH constant.

Sub-module `muldiv_step`:
- combinational single-iteration datapath;
- inputs: mode, 64-bit accumulator, |b|;
- output: next 64-bit accumulator;
- instantiated once in the top.

## Test plan

- MULT a=0xFFFFFFFE (-2), b=3: HI=0xFFFFFFFF, LO=0xFFFFFFFA exactly 33 clocks after start; busy high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7, b=0: LO=0xFFFFFFFF, HI=7.
- MFHI (rd_req=1) issued at cycle 5 of a MULT: stall=1 until busy falls, then rdata equals the new HI. MTLO during busy: LO is unchanged until busy falls, then it takes wdata.
- Assert rst at cycle 10 of a DIV: busy=0 and HI=LO=0 immediately; a new MULTU 6*7 then yields LO=42, HI=0.
- start and hi_we together in IDLE: the operation proceeds and the HI write is dropped. A back-to-back start in the cycle after E33 is accepted with no idle cycle.
